// File: rtl/booth_ctrl_pkg.sv
// rtl/booth_ctrl_pkg.sv - shared states, phase encodings and constants for the Booth operand controller
package booth_ctrl_pkg;

  localparam int DEF_OP_W   = 7;
  localparam int DEF_PROD_W = 14;

  localparam logic [3:0] KEY_CLEAR = 4'hC;

  typedef enum logic [2:0] {
    S_A0    = 3'd0,
    S_A1    = 3'd1,
    S_B0    = 3'd2,
    S_B1    = 3'd3,
    S_START = 3'd4,
    S_WAIT  = 3'd5,
    S_SHOW  = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    PH_A    = 2'd0,
    PH_B    = 2'd1,
    PH_BUSY = 2'd2,
    PH_SHOW = 2'd3
  } phase_t;

  function automatic phase_t phase_of(input state_t s);
    case (s)
      S_A0, S_A1:      phase_of = PH_A;
      S_B0, S_B1:      phase_of = PH_B;
      S_START, S_WAIT: phase_of = PH_BUSY;
      default:         phase_of = PH_SHOW;
    endcase
  endfunction

endpackage

// File: rtl/booth_digit_acc.sv
// rtl/booth_digit_acc.sv - registered decimal accumulator (acc*10 + digit) with clear/load/accumulate
module booth_digit_acc #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         load,
  input  logic         accum,
  input  logic [3:0]   digit,
  output logic [W-1:0] acc,
  output logic [W-1:0] acc_next
);

  // Shift-add form of *10; operands never exceed 99 so nothing can overflow.
  assign acc_next = (acc << 3) + (acc << 1) + W'(digit);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (load) begin
      acc <= W'(digit);
    end else if (accum) begin
      acc <= acc_next;
    end
  end

endmodule

// File: rtl/booth_seq_ctrl.sv
// rtl/booth_seq_ctrl.sv - keypad operand entry and multiplier sequencing; BOOTH_MUL_TIMEOUT_EN adds a done watchdog
module booth_seq_ctrl
  import booth_ctrl_pkg::*;
#(
  parameter int OP_W           = DEF_OP_W,
  parameter int PROD_W         = DEF_PROD_W,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_valid,
  input  logic [3:0]        key_code,
  output logic              mul_start,
  output logic [OP_W-1:0]   mul_a,
  output logic [OP_W-1:0]   mul_b,
  input  logic              mul_done,
  input  logic [PROD_W-1:0] mul_product,
  output logic [OP_W-1:0]   entry_val,
  output logic [1:0]        phase,
  output logic [PROD_W-1:0] result,
  output logic              result_valid,
  output logic              err
);

  state_t state, state_nxt;

  logic is_digit, is_clear;
  logic acc_load, acc_accum, clear_all;
  logic latch_a, latch_b, start_set, latch_res, show_restart, timeout_hit;
  logic tmo;
  logic [OP_W-1:0] acc, acc_next;

  assign is_digit = key_valid && (key_code <= 4'd9);
  assign is_clear = key_valid && (key_code == KEY_CLEAR);

  booth_digit_acc #(.W(OP_W)) u_acc (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear_all),
    .load     (acc_load),
    .accum    (acc_accum),
    .digit    (key_code),
    .acc      (acc),
    .acc_next (acc_next)
  );

`ifdef BOOTH_MUL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;
  logic             err_q;

  assign tmo = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign err = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      wait_cnt <= (state == S_WAIT) ? wait_cnt + 1'b1 : '0;
      if (timeout_hit) begin
        err_q <= 1'b1;
      end else if (state == S_SHOW && (is_digit || is_clear)) begin
        err_q <= 1'b0;
      end
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES > 0);
  assign tmo = 1'b0;
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_A0;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    acc_load     = 1'b0;
    acc_accum    = 1'b0;
    clear_all    = 1'b0;
    latch_a      = 1'b0;
    latch_b      = 1'b0;
    start_set    = 1'b0;
    latch_res    = 1'b0;
    show_restart = 1'b0;
    timeout_hit  = 1'b0;
    case (state)
      S_A0, S_A1, S_B0, S_B1: begin
        if (is_clear) begin
          clear_all = 1'b1;
          state_nxt = S_A0;
        end else if (is_digit) begin
          case (state)
            S_A0: begin acc_load = 1'b1; state_nxt = S_A1; end
            S_A1: begin acc_accum = 1'b1; latch_a = 1'b1; state_nxt = S_B0; end
            S_B0: begin acc_load = 1'b1; state_nxt = S_B1; end
            default: begin
              acc_accum = 1'b1;
              latch_b   = 1'b1;
              start_set = 1'b1;
              state_nxt = S_START;
            end
          endcase
        end
      end
      S_START: state_nxt = S_WAIT;
      // Keys are locked out while busy; done wins over any same-cycle key.
      S_WAIT: begin
        if (mul_done) begin
          latch_res = 1'b1;
          state_nxt = S_SHOW;
        end else if (tmo) begin
          timeout_hit = 1'b1;
          state_nxt   = S_SHOW;
        end
      end
      S_SHOW: begin
        if (is_clear) begin
          clear_all = 1'b1;
          state_nxt = S_A0;
        end else if (is_digit) begin
          acc_load     = 1'b1;
          show_restart = 1'b1;
          state_nxt    = S_A1;
        end
      end
      default: state_nxt = S_A0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mul_start    <= 1'b0;
      mul_a        <= '0;
      mul_b        <= '0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      mul_start <= start_set;
      if (clear_all) begin
        mul_a        <= '0;
        mul_b        <= '0;
        result       <= '0;
        result_valid <= 1'b0;
      end else begin
        if (latch_a) mul_a <= acc_next;
        if (latch_b) mul_b <= acc_next;
        if (show_restart) begin
          mul_b        <= '0;
          result_valid <= 1'b0;
        end
        if (latch_res) begin
          result       <= mul_product;
          result_valid <= 1'b1;
        end
        if (timeout_hit) begin
          result       <= '0;
          result_valid <= 1'b0;
        end
      end
    end
  end

  assign entry_val = acc;
  assign phase     = phase_of(state);

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// tb/tb_booth_seq_ctrl.sv - directed, table-driven bench for booth_seq_ctrl
module tb_booth_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'h0;
  logic        mul_start;
  logic [6:0]  mul_a, mul_b, entry_val;
  logic        mul_done = 1'b0;
  logic [13:0] mul_product = '0;
  logic [1:0]  phase;
  logic [13:0] result;
  logic        result_valid;
  logic        err;

  int passed = 0;
  int total  = 0;
  int start_cnt = 0;

  booth_seq_ctrl #(.OP_W(7), .PROD_W(14), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_done(mul_done), .mul_product(mul_product), .entry_val(entry_val),
    .phase(phase), .result(result), .result_valid(result_valid), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mul_start) start_cnt++;

  typedef struct {
    logic [3:0]  k0, k1, k2, k3;
    logic [6:0]  a, b;
    logic [13:0] p;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic press(input logic [3:0] k);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = k;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'h0;
  endtask

  task automatic pulse_done(input logic [13:0] p);
    mul_done    = 1'b1;
    mul_product = p;
    @(negedge clk);
    mul_done    = 1'b0;
    mul_product = '0;
  endtask

  // Called at the negedge right after the B units key was clocked in.
  task automatic finish_op(input logic [6:0] a, input logic [6:0] b, input logic [13:0] p);
    int s0;
    s0 = start_cnt;
    chk("start_pulse", int'(mul_start), 1);
    chk("busy_phase", int'(phase), 2);
    chk("mul_a", int'(mul_a), int'(a));
    chk("mul_b", int'(mul_b), int'(b));
    @(negedge clk);
    chk("start_single", int'(mul_start), 0);
    repeat (7) @(negedge clk);
    chk("wait_phase", int'(phase), 2);
    pulse_done(p);
    chk("result", int'(result), int'(p));
    chk("result_valid", int'(result_valid), 1);
    chk("show_phase", int'(phase), 3);
    chk("start_count", start_cnt - s0, 1);
  endtask

  task automatic clear_and_check();
    press(4'hC);
    chk("clr_phase", int'(phase), 0);
    chk("clr_result", int'(result), 0);
    chk("clr_rv", int'(result_valid), 0);
    chk("clr_mul_a", int'(mul_a), 0);
  endtask

  initial begin
    int s0;
    vecs[0] = '{k0:4'd1, k1:4'd2, k2:4'd3, k3:4'd4, a:7'd12, b:7'd34, p:14'd408};
    vecs[1] = '{k0:4'd9, k1:4'd9, k2:4'd9, k3:4'd9, a:7'd99, b:7'd99, p:14'd9801};
    vecs[2] = '{k0:4'd1, k1:4'd0, k2:4'd1, k3:4'd0, a:7'd10, b:7'd10, p:14'd100};
    vecs[3] = '{k0:4'd0, k1:4'd7, k2:4'd1, k3:4'd3, a:7'd7,  b:7'd13, p:14'd91};

    repeat (3) @(negedge clk);
    chk("rst_phase", int'(phase), 0);
    chk("rst_mul_start", int'(mul_start), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_rv", int'(result_valid), 0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_entry", int'(entry_val), 0);
    chk("idle_mul_a", int'(mul_a), 0);
    chk("idle_mul_b", int'(mul_b), 0);
    chk("idle_err", int'(err), 0);

    for (int i = 0; i < 4; i++) begin
      press(vecs[i].k0);
      chk("entry_tens_a", int'(entry_val), int'(vecs[i].k0));
      press(vecs[i].k1);
      chk("phase_b", int'(phase), 1);
      press(vecs[i].k2);
      chk("entry_tens_b", int'(entry_val), int'(vecs[i].k2));
      press(vecs[i].k3);
      finish_op(vecs[i].a, vecs[i].b, vecs[i].p);
      clear_and_check();
    end

    // Clear mid-entry
    s0 = start_cnt;
    press(4'd5); press(4'd6); press(4'd7);
    chk("mid_mul_a", int'(mul_a), 56);
    press(4'hC);
    chk("midclr_phase", int'(phase), 0);
    chk("midclr_entry", int'(entry_val), 0);
    chk("midclr_mul_a", int'(mul_a), 0);
    chk("midclr_nostart", start_cnt - s0, 0);

    // Ignored key code and stray done during entry
    press(4'd2);
    press(4'hB);
    chk("ign_phase", int'(phase), 0);
    chk("ign_entry", int'(entry_val), 2);
    pulse_done(14'd999);
    chk("stray_result", int'(result), 0);
    chk("stray_rv", int'(result_valid), 0);
    chk("stray_phase", int'(phase), 0);
    press(4'd0); press(4'd0); press(4'd3);
    finish_op(7'd20, 7'd3, 14'd60);
    clear_and_check();

    // Busy lockout, then key coinciding with done is dropped
    press(4'd1); press(4'd1); press(4'd2); press(4'd2);
    @(negedge clk);
    press(4'd5);
    chk("lock_phase", int'(phase), 2);
    chk("lock_entry", int'(entry_val), 22);
    key_valid = 1'b1;
    key_code  = 4'd7;
    pulse_done(14'd242);
    key_valid = 1'b0;
    key_code  = 4'h0;
    chk("both_phase", int'(phase), 3);
    chk("both_result", int'(result), 242);
    chk("both_entry", int'(entry_val), 22);

    // Digit in S_SHOW restarts operand A
    press(4'd4);
    chk("restart_phase", int'(phase), 0);
    chk("restart_rv", int'(result_valid), 0);
    chk("restart_mul_b", int'(mul_b), 0);
    chk("restart_entry", int'(entry_val), 4);
    press(4'd2);
    chk("restart_phase_b", int'(phase), 1);
    chk("restart_mul_a", int'(mul_a), 42);
    clear_and_check();

    // Reset during S_WAIT, then a late done
    press(4'd1); press(4'd1); press(4'd1); press(4'd1);
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_phase", int'(phase), 2);
    #2 rst = 1'b0;
    #1;
    chk("async_phase", int'(phase), 0);
    chk("async_mul_a", int'(mul_a), 0);
    chk("async_mul_b", int'(mul_b), 0);
    chk("async_entry", int'(entry_val), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    pulse_done(14'd121);
    chk("late_rv", int'(result_valid), 0);
    chk("late_result", int'(result), 0);
    chk("late_phase", int'(phase), 0);

`ifdef BOOTH_MUL_TIMEOUT_EN
    press(4'd3); press(4'd3); press(4'd3); press(4'd3);
    repeat (16) @(negedge clk);
    chk("tmo_not_yet", int'(phase), 2);
    chk("tmo_err_low", int'(err), 0);
    @(negedge clk);
    chk("tmo_phase", int'(phase), 3);
    chk("tmo_err", int'(err), 1);
    chk("tmo_rv", int'(result_valid), 0);
    chk("tmo_result", int'(result), 0);
    press(4'd5);
    chk("tmo_err_clr", int'(err), 0);
    chk("tmo_restart", int'(phase), 0);
    chk("tmo_entry", int'(entry_val), 5);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/booth_seq_ctrl.md
Name: booth_seq_ctrl

Overview:
Operand-entry and sequencing controller for the Booth multiplier datapath. It consumes decoded keypad events and assembles two 2-digit decimal operands, A then B, each 0..99, into binary. It then launches the multiplier with a start/done handshake and latches the product for the 7-segment display path. It sits in module_top between the keypad decoder and the multiplier/display blocks.

Parameters:
OP_W, 7, operand width in bits (holds 0..99)
PROD_W, 14, product width in bits (holds 0..9801)
TIMEOUT_CYCLES, 64, watchdog limit for mul_done (used only with the optional feature)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
key_valid  in  1  one-cycle pulse: key_code is valid
key_code  in  4  0x0-0x9 digit, 0xC clear, other codes ignored
mul_start  out  1  one-cycle start pulse to the multiplier
mul_a  out  OP_W  operand A; held stable from start until done
mul_b  out  OP_W  operand B; held stable from start until done
mul_done  in  1  one-cycle completion pulse from the multiplier
mul_product  in  PROD_W  product; valid in the mul_done cycle
entry_val  out  OP_W  operand currently being typed, for the display
phase  out  2  0 = entering A, 1 = entering B, 2 = busy, 3 = showing result
result  out  PROD_W  latched product
result_valid  out  1  high while in S_SHOW
err  out  1  timeout flag; constant 0 without the feature

Behaviour:
- Reset (async, rst=0): state S_A0. All outputs and registers are 0.
- States:
  - S_A0: tens digit of A
  - S_A1: units digit of A
  - S_B0: tens digit of B
  - S_B1: units digit of B
  - S_START
  - S_WAIT
  - S_SHOW
- Digit accumulation: on a digit key, acc_next = acc*10 + d, computed as (acc<<3)+(acc<<1)+d. No overflow is possible because the maximum is 99.
  - The first digit loads acc = d.
  - entry_val reflects acc one cycle after the key.
- Entry transitions:
  - S_A0 → S_A1 → (A latched into mul_a) S_B0 → S_B1.
  - The units digit of B latches mul_b and moves to S_START.
- Launch timing: if the B units key arrives in cycle n, mul_start=1 in cycle n+1 (registered) and the state is S_WAIT in cycle n+2. Exactly one start pulse per operation.
- S_WAIT: on mul_done, result <= mul_product, then go to S_SHOW. result_valid is high from the next cycle.
- S_SHOW:
  - A digit key clears result_valid and B, loads A tens with that digit, and goes to S_A1.
  - A clear key goes to S_A0.
- Clear key (0xC):
  - In S_A0..S_B1 or S_SHOW: go to S_A0; acc, mul_a, mul_b, result and result_valid are zeroed.
  - Ignored in S_START and S_WAIT.
- Busy lockout: all keys are ignored in S_START and S_WAIT.
- mul_done outside S_WAIT is ignored.
- A key and mul_done in the same S_WAIT cycle: done is processed and the key is dropped.
- Ignored key codes (0xA, 0xB, 0xD-0xF) cause no state or register change.
- Reset mid-operation, including S_WAIT: immediate return to the reset state. A later stray mul_done is ignored.
- phase is a pure function of the state.

Optional Feature:
Macro BOOTH_MUL_TIMEOUT_EN.
- Defined:
  - A counter runs in S_WAIT.
  - If mul_done has not arrived after TIMEOUT_CYCLES cycles, set err=1 and go to S_SHOW with result=0 and result_valid=0.
  - err clears on the next key accepted in S_SHOW, or on reset.
- Undefined: no counter; err is tied to 0; S_WAIT waits indefinitely.

Decomposition:
- Package booth_ctrl_pkg holds:
  - the state enum (3-bit) and phase encodings
  - the KEY_CLEAR=4'hC constant
  - the default OP_W/PROD_W constants
- One sub-module, booth_digit_acc: registered ×10+d accumulator with load/accumulate/clear controls, instantiated once.

Test Plan:
- Keys 1,2,3,4; model mul_done 8 cycles after start with product 408 → mul_a=12, mul_b=34, exactly one mul_start, result=408, result_valid=1, phase=3.
- Keys 9,9,9,9; done with product 9801 → result=9801 (0x2649), no width truncation.
- Keys 5,6,7 then 0xC → state S_A0, entry_val=0, no mul_start. Then 1,0,1,0 with product 100 → result=100.
- Key 0xB between digits, plus mul_done pulsed during S_A1 → both ignored. Keys 2,0,0,3 → product 60 is latched.
- rst low during S_WAIT, then a late mul_done → all outputs 0, state S_A0, result_valid stays 0.
- With BOOTH_MUL_TIMEOUT_EN and TIMEOUT_CYCLES=16, no mul_done → err=1 after 16 cycles, result_valid=0. The next digit key clears err and starts operand A.
